led_mode_sequencer: RTL and testbench

LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

---
 rtl/led_mode_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_mode_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - debounced push button stepping LED pattern modes OFF/ALL/BLINK/SHIFT/COUNT
// Optional long-press return to OFF: define LED_SEQ_LONGPRESS_EN.
module led_mode_sequencer #(
  parameter int DB_CYCLES   = 4,
  parameter int TICK_DIV    = 8,
  parameter int LONG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       mode_ext,
  output logic [3:0] led,
  output logic [2:0] mode,
  output logic       press
);
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_ALL   = 3'd1,
    S_BLINK = 3'd2,
    S_SHIFT = 3'd3,
    S_COUNT = 3'd4
  } state_t;

  localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 255 || TICK_DIV < 2 || TICK_DIV > 65535 || LONG_CYCLES < 2)
  begin : g_param_check
    $error("led_mode_sequencer: parameter out of range");
  end

  state_t      state, next_state;
  logic        sync1, sync, db, db_d, armed;
  logic [1:0]  fill;
  logic [7:0]  db_cnt;
  logic [15:0] presc, presc_next;
  logic [3:0]  pat, pat_next;
  logic        long_hit, chg, tick;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= mode_ext;
      sync  <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  // armed stays low until the button is seen released once the synchronizer holds real samples
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= 8'd0;
      armed  <= 1'b0;
      press  <= 1'b0;
    end else begin
      db_d  <= db;
      press <= db & ~db_d & armed;
      if (sync == db) begin
        db_cnt <= 8'd0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync;
        db_cnt <= 8'd0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
      if (fill[1] && !sync && !db) armed <= 1'b1;
    end
  end

`ifdef LED_SEQ_LONGPRESS_EN
  localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);
  logic [15:0] long_cnt;
  logic        long_done;

  assign long_hit = db && !long_done && (long_cnt == LONG_LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      long_cnt  <= 16'd0;
      long_done <= 1'b0;
    end else if (!db) begin
      long_cnt  <= 16'd0;
      long_done <= 1'b0;
    end else if (long_hit) begin
      long_done <= 1'b1;
    end else if (!long_done) begin
      long_cnt <= long_cnt + 16'd1;
    end
  end
`else
  assign long_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_OFF;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (long_hit) begin
      next_state = S_OFF;
    end else if (press) begin
      case (state)
        S_OFF:   next_state = S_ALL;
        S_ALL:   next_state = S_BLINK;
        S_BLINK: next_state = S_SHIFT;
        S_SHIFT: next_state = S_COUNT;
        default: next_state = S_OFF;
      endcase
    end
  end

  // a mode change reloads the prescaler and pattern instead of ticking
  always_comb begin
    chg        = (next_state != state);
    tick       = (presc == TICK_LAST) && !chg;
    presc_next = (chg || tick) ? 16'd0 : presc + 16'd1;
    pat_next   = pat;
    if (chg) begin
      case (next_state)
        S_ALL, S_BLINK: pat_next = 4'hF;
        S_SHIFT:        pat_next = 4'h1;
        default:        pat_next = 4'h0;
      endcase
    end else if (tick) begin
      case (state)
        S_BLINK: pat_next = ~pat;
        S_SHIFT: pat_next = {pat[2:0], pat[3]};
        S_COUNT: pat_next = pat + 4'd1;
        default: pat_next = pat;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc <= 16'd0;
      pat   <= 4'h0;
    end else begin
      presc <= presc_next;
      pat   <= pat_next;
    end
  end

  assign mode = state;
  assign led  = pat;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - randomized bench for led_mode_sequencer against a mode/elapsed-time model
module tb_led_mode_sequencer;
  localparam int DB = 4;
  localparam int TD = 8;
  localparam int LC = 64;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       mode_ext = 1'b0;
  logic [3:0] led;
  logic [2:0] mode;
  logic       press;

  int total = 0;
  int bad   = 0;
  int d_np  = 0;

  // model: button history, debounced level, and mode plus cycles since entering it
  bit m_s1, m_s2, m_db, m_rose, m_armed, m_press, m_ldone;
  int m_run, m_k, m_hr, m_mode, m_el;

  led_mode_sequencer #(.DB_CYCLES(DB), .TICK_DIV(TD), .LONG_CYCLES(LC)) dut (
    .clk(clk), .clr_n(clr_n), .mode_ext(mode_ext),
    .led(led), .mode(mode), .press(press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] led_of(input int md, input int el);
    int t;
    t = el / TD;
    case (md)
      1:       return 4'hF;
      2:       return (t % 2 == 0) ? 4'hF : 4'h0;
      3:       return 4'(1 << (t % 4));
      4:       return 4'(t % 16);
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_rose = 0; m_armed = 0; m_press = 0; m_ldone = 0;
    m_run = 0; m_k = 0; m_hr = 0; m_mode = 0; m_el = 0;
  endtask

  task automatic model_edge(input bit b);
    bit sync_pre, db_pre, armed_pre, press_pre, hit;
    int nm;
    sync_pre = m_s2; m_s2 = m_s1; m_s1 = b;
    db_pre = m_db; armed_pre = m_armed; press_pre = m_press;
    if (sync_pre != m_db) begin
      m_run++;
      if (m_run == DB) begin m_db = sync_pre; m_run = 0; end
    end else begin
      m_run = 0;
    end
    if (!m_armed && m_k >= 2 && !sync_pre && !db_pre) m_armed = 1;
    if (m_k < 2) m_k++;
    m_press = m_rose && armed_pre;
    m_rose  = !db_pre && m_db;
    hit = 0;
`ifdef LED_SEQ_LONGPRESS_EN
    if (db_pre) begin
      if (!m_ldone) begin
        m_hr++;
        if (m_hr == LC) begin hit = 1; m_ldone = 1; end
      end
    end else begin
      m_hr = 0; m_ldone = 0;
    end
`endif
    nm = hit ? 0 : (press_pre ? (m_mode + 1) % 5 : m_mode);
    if (nm != m_mode) begin m_mode = nm; m_el = 0; end
    else m_el++;
  endtask

  task automatic step(input logic b);
    mode_ext = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    if (press === 1'b1) d_np++;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("led", 32'(led), 32'(led_of(m_mode, m_el)));
    chk("press", 32'(press), 32'(m_press));
  endtask

  task automatic push(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 6 && m_mode != target; i++) push(8, 8);
    chk("goto_mode", 32'(mode), 32'(target));
  endtask

  task automatic async_reset(input logic hold_btn);
    mode_ext = hold_btn;
    #2 clr_n = 1'b0;
    #1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_press", 32'(press), 32'd0);
    model_reset();
    @(negedge clk);
    #2 clr_n = 1'b1;
  endtask

  initial begin
    int np0, gm;
    model_reset();
    #2;
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_press", 32'(press), 32'd0);
    #2 clr_n = 1'b1;

    // single clean press from OFF
    repeat (3) step(1'b0);
    push(8, 8);
    chk("first_mode", 32'(mode), 32'd1);
    chk("first_led", 32'(led), 32'hF);
    chk("first_press_cnt", 32'(d_np), 32'd1);

    // full cycle through all modes, one press per push
    np0 = d_np;
    for (int i = 0; i < 6; i++) begin
      push(8, 8);
      chk("cycle_mode", 32'(mode), 32'((i + 2) % 5));
    end
    chk("cycle_press_cnt", 32'(d_np - np0), 32'd6);

    // SHIFT rotation and COUNT wrap across 17 ticks
    goto_mode(3);
    repeat (4 * TD + 4) step(1'b0);
    goto_mode(4);
    repeat (17 * TD + 4) step(1'b0);

    // glitch train shorter than the debounce window
    gm = m_mode;
    np0 = d_np;
    for (int i = 0; i < 40; i++) step(i[0]);
    repeat (6) step(1'b0);
    chk("glitch_mode", 32'(mode), 32'(gm));
    chk("glitch_press_cnt", 32'(d_np - np0), 32'd0);

    // reset mid-debounce in BLINK with the button held through release
    goto_mode(2);
    step(1'b1);
    step(1'b1);
    async_reset(1'b1);
    np0 = d_np;
    repeat (20) step(1'b1);
    chk("held_press_cnt", 32'(d_np - np0), 32'd0);
    chk("held_mode", 32'(mode), 32'd0);
    push(0, 10);
    push(8, 8);
    chk("rearm_mode", 32'(mode), 32'd1);

    // long hold in COUNT
    goto_mode(4);
    push(100, 10);

    // random bouncy presses and idle gaps
    for (int n = 0; n < 150; n++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 14));
      lo = int'($urandom_range(1, 14));
      for (int c = 0; c < hi; c++) step(($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
      for (int c = 0; c < lo; c++) step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(0, 60))) step(1'b0);
      if (n == 75) begin
        async_reset(1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
